// File: rtl/maxpool_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_pkg
// Shared constants and the controller state encoding for the 2x2 max-pool
// engine. DATA_WIDTH / IMG_DIM here are the defaults used by the modules;
// the modules accept overrides through their own parameters.
// ---------------------------------------------------------------------------
package maxpool_pkg;

    localparam int DATA_WIDTH = 20;     // signed 4.16 fixed point
    localparam int IMG_DIM    = 64;     // source image side, power of two >= 4
    localparam int RD_AW      = $clog2(IMG_DIM * IMG_DIM);
    localparam int WR_AW      = $clog2((IMG_DIM / 2) * (IMG_DIM / 2));

    // One 2x2 window walks RD0..WR (6 cycles); DONE closes the pass.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RD3  = 3'd4,
        LAST = 3'd5,
        WR   = 3'd6,
        DONE = 3'd7
    } state_t;

endpackage

// File: rtl/maxpool_ctrl_if.sv
// ---------------------------------------------------------------------------
// maxpool_ctrl_if
// Control handshake plus source-read and pooled-write buses of the max-pool
// controller.
//   start   : one-cycle pulse that begins a pass
//   busy    : pass in progress
//   done    : one-cycle pulse after the last write
//   rd_en / rd_addr / rd_data : source memory read (data one cycle later)
//   wr_en / wr_addr / wr_data : pooled memory write
// master : the controller side;  slave : the memory/host side.
// ---------------------------------------------------------------------------
interface maxpool_ctrl_if #(
    parameter int DATA_WIDTH = maxpool_pkg::DATA_WIDTH,
    parameter int IMG_DIM    = maxpool_pkg::IMG_DIM
);
    localparam int L_RD_AW = $clog2(IMG_DIM * IMG_DIM);
    localparam int L_WR_AW = $clog2((IMG_DIM / 2) * (IMG_DIM / 2));

    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         rd_en;
    logic [L_RD_AW-1:0]           rd_addr;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic                         wr_en;
    logic [L_WR_AW-1:0]           wr_addr;
    logic signed [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  start, rd_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/maxpool_four_num_sorter.sv
// ---------------------------------------------------------------------------
// four_num_sorter
// Combinational signed maximum of four values (two-level comparator tree).
//   i_a..i_d : signed inputs
//   o_max    : largest input; ties return an identical value
// ---------------------------------------------------------------------------
module four_num_sorter #(
    parameter int DATA_WIDTH = maxpool_pkg::DATA_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    input  logic signed [DATA_WIDTH-1:0] i_c,
    input  logic signed [DATA_WIDTH-1:0] i_d,
    output logic signed [DATA_WIDTH-1:0] o_max
);

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [DATA_WIDTH-1:0] y
    );
        if (x > y) begin
            return x;
        end else begin
            return y;
        end
    endfunction

    logic signed [DATA_WIDTH-1:0] w_max_ab;
    logic signed [DATA_WIDTH-1:0] w_max_cd;

    // Comparator tree: pairwise maxima, then the final maximum.
    always_comb begin
        w_max_ab = smax(i_a, i_b);
        w_max_cd = smax(i_c, i_d);
        o_max    = smax(w_max_ab, w_max_cd);
    end

endmodule

// File: rtl/maxpool_ctrl.sv
// ---------------------------------------------------------------------------
// maxpool_ctrl
// Walks an IMG_DIM x IMG_DIM signed image in 2x2 windows (row-major over the
// window grid), reads the four pixels, and writes their signed maximum to the
// pooled image.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; aborts any pass at that edge
//   bus   : maxpool_ctrl_if.master (start/busy/done, read bus, write bus)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module maxpool_ctrl #(
    parameter int DATA_WIDTH = maxpool_pkg::DATA_WIDTH,
    parameter int IMG_DIM    = maxpool_pkg::IMG_DIM
) (
    input  logic           clk,
    input  logic           reset,
    maxpool_ctrl_if.master bus
);
    import maxpool_pkg::*;

    localparam int LB      = $clog2(IMG_DIM);
    localparam int L_RD_AW = 2 * LB;
    localparam int L_WR_AW = 2 * (LB - 1);

    localparam logic [LB-1:0] LAST_POS = LB'(IMG_DIM - 2);
    localparam logic [LB-1:0] STEP     = LB'(2);
    localparam logic [LB-1:0] ONE      = LB'(1);

    state_t                       r_state, w_next_state;
    logic [LB-1:0]                r_row, r_col, w_next_row, w_next_col;
    logic signed [DATA_WIDTH-1:0] r_win_a, r_win_b, r_win_c, r_win_d;
    logic signed [DATA_WIDTH-1:0] w_sort_d, w_max;
    logic                         w_rd_strobe;
    logic [L_RD_AW-1:0]           w_rd_addr;
    logic [L_WR_AW-1:0]           w_wr_addr;

    logic                         r_busy, r_done, r_rd_en, r_wr_en;
    logic [L_RD_AW-1:0]           r_rd_addr;
    logic [L_WR_AW-1:0]           r_wr_addr;
    logic signed [DATA_WIDTH-1:0] r_wr_data;

    // State register and window position counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_next_state;
            r_row   <= w_next_row;
            r_col   <= w_next_col;
        end
    end

    // Next state and next window position; the position advances leaving WR.
    always_comb begin
        w_next_state = r_state;
        w_next_row   = r_row;
        w_next_col   = r_col;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = RD0;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RD0:  w_next_state = RD1;
            RD1:  w_next_state = RD2;
            RD2:  w_next_state = RD3;
            RD3:  w_next_state = LAST;
            LAST: w_next_state = WR;
            WR: begin
                if ((r_row == LAST_POS) && (r_col == LAST_POS)) begin
                    w_next_state = DONE;
                    w_next_row   = '0;
                    w_next_col   = '0;
                end else if (r_col == LAST_POS) begin
                    w_next_state = RD0;
                    w_next_row   = r_row + STEP;
                    w_next_col   = '0;
                end else begin
                    w_next_state = RD0;
                    w_next_col   = r_col + STEP;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Read strobe/address for the state being entered; row/col are even, so
    // the +1 neighbours are formed by setting bit 0.
    always_comb begin
        w_rd_strobe = 1'b0;
        w_rd_addr   = '0;
        case (w_next_state)
            RD0: begin
                w_rd_strobe = 1'b1;
                w_rd_addr   = {w_next_row, w_next_col};
            end
            RD1: begin
                w_rd_strobe = 1'b1;
                w_rd_addr   = {w_next_row, w_next_col | ONE};
            end
            RD2: begin
                w_rd_strobe = 1'b1;
                w_rd_addr   = {w_next_row | ONE, w_next_col};
            end
            RD3: begin
                w_rd_strobe = 1'b1;
                w_rd_addr   = {w_next_row | ONE, w_next_col | ONE};
            end
            default: begin
                w_rd_strobe = 1'b0;
                w_rd_addr   = '0;
            end
        endcase
    end

    // Pooled address = (row/2)*(IMG_DIM/2) + col/2.
    assign w_wr_addr = {r_row[LB-1:1], r_col[LB-1:1]};

    // Window sample capture, one cycle after each read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_a <= '0;
            r_win_b <= '0;
            r_win_c <= '0;
            r_win_d <= '0;
        end else begin
            case (r_state)
                RD1:     r_win_a <= bus.rd_data;
                RD2:     r_win_b <= bus.rd_data;
                RD3:     r_win_c <= bus.rd_data;
                LAST:    r_win_d <= bus.rd_data;
                default: begin
                end
            endcase
        end
    end

    // The fourth sample is still on rd_data during LAST, the same edge that
    // loads the registered write outputs, so it bypasses win_d there.
    always_comb begin
        if (r_state == LAST) begin
            w_sort_d = bus.rd_data;
        end else begin
            w_sort_d = r_win_d;
        end
    end

    four_num_sorter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sorter (
        .i_a   (r_win_a),
        .i_b   (r_win_b),
        .i_c   (r_win_c),
        .i_d   (w_sort_d),
        .o_max (w_max)
    );

    // Registered outputs, all decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_busy    <= (w_next_state != IDLE);
            r_done    <= (w_next_state == DONE);
            r_rd_en   <= w_rd_strobe;
            r_rd_addr <= w_rd_addr;
            r_wr_en   <= (w_next_state == WR);
            if (w_next_state == WR) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_max;
            end else begin
                r_wr_addr <= '0;   // wr_data keeps its last value
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// ---------------------------------------------------------------------------
// tb_maxpool_ctrl
// Two controller instances (IMG_DIM=64 and IMG_DIM=8) with behavioural source
// memories. Expected writes are queued when a pass is launched and popped by
// a monitor whenever wr_en is seen.
// ---------------------------------------------------------------------------
module tb_maxpool_ctrl;

    localparam int DW = 20;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    maxpool_ctrl_if #(.DATA_WIDTH(DW), .IMG_DIM(64)) b64 ();
    maxpool_ctrl_if #(.DATA_WIDTH(DW), .IMG_DIM(8))  b8 ();

    maxpool_ctrl #(.DATA_WIDTH(DW), .IMG_DIM(64)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (b64.master)
    );

    maxpool_ctrl #(.DATA_WIDTH(DW), .IMG_DIM(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8.master)
    );

    logic signed [DW-1:0] mem64 [0:4095];
    logic signed [DW-1:0] mem8  [0:63];

    // Source memories: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (b64.rd_en) b64.rd_data <= mem64[b64.rd_addr];
        if (b8.rd_en)  b8.rd_data  <= mem8[b8.rd_addr];
    end

    typedef struct {
        int                   addr;
        logic signed [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic signed [DW-1:0] a, b, c, d, exp;
    } vec_t;

    wr_t q64[$];
    wr_t q8[$];
    int  rd8_log[$];
    int  wr8_log[$];

    int errors   = 0;
    int checks   = 0;
    int wr64_n   = 0;
    int done64_n = 0;
    int wr8_n    = 0;
    int done8_n  = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse64();
        b64.start = 1'b1;
        @(negedge clk);
        b64.start = 1'b0;
    endtask

    // Scoreboard monitor for the 64x64 instance.
    initial begin : mon64
        wr_t e;
        forever begin
            @(negedge clk);
            if (b64.wr_en) begin
                wr64_n++;
                if (q64.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr64_unexpected: got write to %0d, expected no write", b64.wr_addr);
                end else begin
                    e = q64.pop_front();
                    chk("wr64_addr", b64.wr_addr, e.addr);
                    chk("wr64_data", b64.wr_data, e.data);
                end
            end else begin
                chk("wr64_addr_idle", b64.wr_addr, 0);
            end
            if (!b64.rd_en) chk("rd64_addr_idle", b64.rd_addr, 0);
            if (b64.done) done64_n++;
        end
    end

    // Scoreboard monitor and address log for the 8x8 instance.
    initial begin : mon8
        wr_t e;
        forever begin
            @(negedge clk);
            if (b8.rd_en) rd8_log.push_back(int'(b8.rd_addr));
            if (b8.wr_en) begin
                wr8_n++;
                wr8_log.push_back(int'(b8.wr_addr));
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr8_unexpected: got write to %0d, expected no write", b8.wr_addr);
                end else begin
                    e = q8.pop_front();
                    chk("wr8_addr", b8.wr_addr, e.addr);
                    chk("wr8_data", b8.wr_data, e.data);
                end
            end
            if (!b8.rd_en) chk("rd8_addr_idle", b8.rd_addr, 0);
            if (b8.done) done8_n++;
        end
    end

    initial begin : main
        vec_t vecs[5];
        int   exp_wrap[8];
        int   cnt;
        int   bad;
        int   w0;
        int   d0;
        int   idx;

        vecs[0] = '{-20'sd5, -20'sd1, -20'sd7, -20'sd3, -20'sd1};
        vecs[1] = '{20'sd8, 20'sd8, 20'sd8, 20'sd8, 20'sd8};
        vecs[2] = '{20'sd1, 20'sd2, 20'sd3, 20'sh7FFFF, 20'sh7FFFF};
        vecs[3] = '{20'sd100, -20'sd100, 20'sd50, 20'sd99, 20'sd100};
        vecs[4] = '{20'sh80000, 20'sh80000, 20'sh80001, 20'sh80000, 20'sh80001};
        exp_wrap = '{6, 7, 14, 15, 16, 17, 24, 25};

        reset     = 1'b1;
        b64.start = 1'b0;
        b8.start  = 1'b0;
        for (int i = 0; i < 4096; i++) mem64[i] = DW'(i);
        for (int i = 0; i < 64; i++)   mem8[i]  = DW'(i);

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_busy",    b64.busy, 0);
        chk("rst_done",    b64.done, 0);
        chk("rst_rd_en",   b64.rd_en, 0);
        chk("rst_wr_en",   b64.wr_en, 0);
        chk("rst_rd_addr", b64.rd_addr, 0);
        chk("rst_wr_addr", b64.wr_addr, 0);
        chk("rst_wr_data", b64.wr_data, 0);
        chk("rst_busy8",   b8.busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- 8x8 full pass, row wrap ----------------
        for (int k = 0; k < 16; k++)
            q8.push_back('{k, DW'((2 * (k / 4) + 1) * 8 + 2 * (k % 4) + 1)});
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        cnt = 0;
        while (!b8.done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("d8_done_cycle", cnt, 96);
        @(negedge clk);
        chk("d8_done_width", b8.done, 0);
        chk("d8_busy_after", b8.busy, 0);
        chk("d8_writes",     wr8_n, 16);
        chk("d8_done_count", done8_n, 1);
        chk("d8_q_empty",    q8.size(), 0);
        chk("d8_reads",      rd8_log.size(), 64);
        if (rd8_log.size() >= 20) begin
            for (int i = 0; i < 8; i++) chk("d8_wrap_rd", rd8_log[12 + i], exp_wrap[i]);
        end
        if (wr8_log.size() >= 5) begin
            chk("d8_wrap_wr3", wr8_log[3], 3);
            chk("d8_wrap_wr4", wr8_log[4], 4);
        end

        // ---------------- window-0 vectors (abort after first write) ----------------
        for (int v = 0; v < 5; v++) begin
            mem64[0]  = vecs[v].a;
            mem64[1]  = vecs[v].b;
            mem64[64] = vecs[v].c;
            mem64[65] = vecs[v].d;
            q64.push_back('{0, vecs[v].exp});
            pulse64();
            cnt = 0;
            while (!b64.wr_en && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            chk("vec_wr_latency", cnt, 5);
            @(negedge clk);
            chk("vec_wr_en_drop", b64.wr_en, 0);
            chk("vec_wr_hold",    b64.wr_data, vecs[v].exp);
            chk("vec_consumed",   q64.size(), 0);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            q64.delete();
        end
        mem64[0]  = DW'(0);
        mem64[1]  = DW'(1);
        mem64[64] = DW'(64);
        mem64[65] = DW'(65);

        // ---------------- ramp pass with a stray start ----------------
        for (int k = 0; k < 1024; k++) begin
            idx = (2 * (k / 32) + 1) * 64 + 2 * (k % 32) + 1;
            q64.push_back('{k, mem64[idx]});
        end
        w0 = wr64_n;
        d0 = done64_n;
        pulse64();
        chk("ramp_rd0_en",   b64.rd_en, 1);
        chk("ramp_rd0_addr", b64.rd_addr, 0);
        chk("ramp_busy",     b64.busy, 1);
        cnt = 0;
        while (!b64.done && cnt < 7000) begin
            if (cnt == 100) b64.start = 1'b1;
            else            b64.start = 1'b0;
            @(negedge clk);
            cnt++;
        end
        b64.start = 1'b0;
        chk("ramp_done_cycle", cnt, 6144);
        @(negedge clk);
        chk("ramp_done_width",  b64.done, 0);
        chk("ramp_writes",      wr64_n - w0, 1024);
        chk("ramp_done_pulses", done64_n - d0, 1);
        chk("ramp_q_empty",     q64.size(), 0);
        repeat (10) @(negedge clk);
        chk("ramp_no_restart_busy", b64.busy, 0);
        chk("ramp_no_restart_rd",   b64.rd_en, 0);

        // ---------------- reset mid-pass ----------------
        for (int k = 0; k < 1024; k++) begin
            idx = (2 * (k / 32) + 1) * 64 + 2 * (k % 32) + 1;
            q64.push_back('{k, mem64[idx]});
        end
        d0 = done64_n;
        pulse64();
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy",  b64.busy, 0);
        chk("abort_rd_en", b64.rd_en, 0);
        chk("abort_wr_en", b64.wr_en, 0);
        chk("abort_done",  b64.done, 0);
        reset = 1'b0;
        q64.delete();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b64.rd_en || b64.wr_en || b64.done || b64.busy) bad++;
        end
        chk("abort_quiet",      bad, 0);
        chk("abort_done_count", done64_n - d0, 0);

        pulse64();
        chk("restart_rd_en", b64.rd_en, 1);
        chk("restart_rd0",   b64.rd_addr, 0);
        @(negedge clk);
        chk("restart_rd1",   b64.rd_addr, 1);
        @(negedge clk);
        chk("restart_rd2",   b64.rd_addr, 64);
        @(negedge clk);
        chk("restart_rd3",   b64.rd_addr, 65);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
